// File: rtl/game_state_mux_pkg.sv
// Shared definitions for the pong display pipeline source selector.
// Holds the screen geometry, the applied-mode encoding and the centred
// default coordinates used whenever remote data is stale.
package game_state_mux_pkg;

    localparam int HOR_PIXELS = 640;
    localparam int VER_PIXELS = 480;
    localparam int BALL_SIZE  = 16;
    localparam int PAD_HEIGHT = 80;

    typedef enum logic [1:0] {
        MODE_HOST   = 2'd0,
        MODE_LOCAL  = 2'd1,
        MODE_CLIENT = 2'd2
    } mux_mode_t;

    // Top-left coordinates that put the ball / paddle in the middle of the screen.
    localparam int BALL_X_CENTRE = (HOR_PIXELS - BALL_SIZE) / 2;
    localparam int BALL_Y_CENTRE = (VER_PIXELS - BALL_SIZE) / 2;
    localparam int PAD_Y_CENTRE  = (VER_PIXELS - PAD_HEIGHT) / 2;

endpackage

// File: rtl/game_state_mux_if.sv
// Bundle of the frame strobe, role switches, local and remote coordinate
// sources and the committed outputs of game_state_mux.
//   master : drives frame_tick, sw, *_logic, uart_*; observes *_mux, mode_active, link_ok
//   slave  : the selector itself (reverse directions)
interface game_state_mux_if
    import game_state_mux_pkg::*;
#(
    parameter int X_W = 11,
    parameter int Y_W = 10
);
    logic            frame_tick;
    logic [1:0]      sw;
    logic [X_W-1:0]  x_ball_logic;
    logic [Y_W-1:0]  y_ball_logic;
    logic [Y_W-1:0]  y_player1_logic;
    logic [Y_W-1:0]  y_player2_logic;
    logic            uart_valid;
    logic [X_W-1:0]  x_ball_uart;
    logic [Y_W-1:0]  y_ball_uart;
    logic [Y_W-1:0]  y_pad_uart;
    logic [X_W-1:0]  x_ball_mux;
    logic [Y_W-1:0]  y_ball_mux;
    logic [Y_W-1:0]  y_player1_mux;
    logic [Y_W-1:0]  y_player2_mux;
    mux_mode_t       mode_active;
    logic            link_ok;

    modport master (
        output frame_tick, sw, x_ball_logic, y_ball_logic, y_player1_logic,
               y_player2_logic, uart_valid, x_ball_uart, y_ball_uart, y_pad_uart,
        input  x_ball_mux, y_ball_mux, y_player1_mux, y_player2_mux,
               mode_active, link_ok
    );

    modport slave (
        input  frame_tick, sw, x_ball_logic, y_ball_logic, y_player1_logic,
               y_player2_logic, uart_valid, x_ball_uart, y_ball_uart, y_pad_uart,
        output x_ball_mux, y_ball_mux, y_player1_mux, y_player2_mux,
               mode_active, link_ok
    );

endinterface

// File: rtl/game_state_mux_link_watchdog.sv
// Link watchdog: counts frames since the last received UART frame.
//   clk, rst   : clock, synchronous active-high reset
//   frame_tick : one-cycle frame strobe, ages the link
//   rx_strobe  : one-cycle receive strobe, refreshes the link
//   link_ok    : freshness as it will stand after this cycle
//                (rx_age_d < TIMEOUT_FRAMES); the caller registers it
module link_watchdog #(
    parameter int TIMEOUT_FRAMES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_tick,
    input  logic rx_strobe,
    output logic link_ok
);

    localparam int AW = $clog2(TIMEOUT_FRAMES + 1);
    localparam logic [AW-1:0] AGE_MAX = AW'(TIMEOUT_FRAMES);

    logic [AW-1:0] rx_age_q, rx_age_d;

    // A receive in the same cycle as a frame tick resets the age.
    always_comb begin
        rx_age_d = rx_age_q;
        if (rx_strobe) begin
            rx_age_d = '0;
        end else if (frame_tick && (rx_age_q != AGE_MAX)) begin
            rx_age_d = rx_age_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_age_q <= AGE_MAX;
        end else begin
            rx_age_q <= rx_age_d;
        end
    end

    // Exposed combinationally so a commit on a frame tick already sees the
    // post-tick freshness; the selector registers it for its own output.
    assign link_ok = (rx_age_d < AGE_MAX);

endmodule

// File: rtl/game_state_mux.sv
// Frame-synchronous source selector for the pong draw stage.
// Picks ball/paddle coordinates from local logic or the UART shadow copy
// depending on the debounced board role, commits them only on frame_tick,
// and substitutes centred defaults for remote data when the link is stale.
//   clk, rst : clock, synchronous active-high reset
//   bus      : game_state_mux_if.slave (frame_tick, sw, local and UART
//              coordinates in; committed coordinates, mode_active, link_ok out)
module game_state_mux
    import game_state_mux_pkg::*;
#(
    parameter int X_W            = 11,
    parameter int Y_W            = 10,
    parameter int TIMEOUT_FRAMES = 8,
    parameter int DEB_FRAMES     = 2
) (
    input logic              clk,
    input logic              rst,
    game_state_mux_if.slave  bus
);

    localparam logic [X_W-1:0] X_CENTRE   = X_W'(BALL_X_CENTRE);
    localparam logic [Y_W-1:0] Y_CENTRE   = Y_W'(BALL_Y_CENTRE);
    localparam logic [Y_W-1:0] PAD_CENTRE = Y_W'(PAD_Y_CENTRE);

    localparam int CW = $clog2(DEB_FRAMES + 1);
    localparam logic [CW-1:0] DEB_MAX = CW'(DEB_FRAMES);

    // UART shadow copies
    logic [X_W-1:0] sh_x_q;
    logic [Y_W-1:0] sh_y_q, sh_pad_q;

    // Debounce and applied mode
    mux_mode_t      mode_dec;
    mux_mode_t      cand_q, cand_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    mux_mode_t      mode_q, mode_d;

    // Committed outputs and their next values
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d, p1_q, p1_d, p2_q, p2_d;
    logic           link_q;
    logic           link_fresh;

    link_watchdog #(
        .TIMEOUT_FRAMES (TIMEOUT_FRAMES)
    ) u_watchdog (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (bus.frame_tick),
        .rx_strobe  (bus.uart_valid),
        .link_ok    (link_fresh)
    );

    // Role decode (sw[0] wins) and frame-tick debounce. The mode applied on a
    // tick is the post-debounce one, so the commit below uses mode_d.
    always_comb begin
        if (bus.sw[0]) begin
            mode_dec = MODE_CLIENT;
        end else if (bus.sw[1]) begin
            mode_dec = MODE_LOCAL;
        end else begin
            mode_dec = MODE_HOST;
        end

        cand_d = cand_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        if (bus.frame_tick) begin
            if (mode_dec == cand_q) begin
                if (cnt_q != DEB_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                cand_d = mode_dec;
                cnt_d  = CW'(1);
            end
            if ((cnt_d == DEB_MAX) && (cand_d != mode_q)) begin
                mode_d = cand_d;
            end
        end
    end

    // Source selection; any shadow-sourced field falls back to its centre
    // value when the link is down.
    always_comb begin
        x_d  = bus.x_ball_logic;
        y_d  = bus.y_ball_logic;
        p1_d = bus.y_player1_logic;
        p2_d = bus.y_player2_logic;
        case (mode_d)
            MODE_HOST: begin
                p2_d = link_fresh ? sh_pad_q : PAD_CENTRE;
            end
            MODE_CLIENT: begin
                x_d  = link_fresh ? sh_x_q   : X_CENTRE;
                y_d  = link_fresh ? sh_y_q   : Y_CENTRE;
                p1_d = link_fresh ? sh_pad_q : PAD_CENTRE;
                p2_d = bus.y_player1_logic;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_x_q   <= X_CENTRE;
            sh_y_q   <= Y_CENTRE;
            sh_pad_q <= PAD_CENTRE;
            cand_q   <= MODE_LOCAL;
            cnt_q    <= '0;
            mode_q   <= MODE_LOCAL;
            x_q      <= X_CENTRE;
            y_q      <= Y_CENTRE;
            p1_q     <= PAD_CENTRE;
            p2_q     <= PAD_CENTRE;
            link_q   <= 1'b0;
        end else begin
            if (bus.uart_valid) begin
                sh_x_q   <= bus.x_ball_uart;
                sh_y_q   <= bus.y_ball_uart;
                sh_pad_q <= bus.y_pad_uart;
            end
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            if (bus.frame_tick) begin
                x_q    <= x_d;
                y_q    <= y_d;
                p1_q   <= p1_d;
                p2_q   <= p2_d;
                link_q <= link_fresh;
            end
        end
    end

    assign bus.x_ball_mux    = x_q;
    assign bus.y_ball_mux    = y_q;
    assign bus.y_player1_mux = p1_q;
    assign bus.y_player2_mux = p2_q;
    assign bus.mode_active   = mode_q;
    assign bus.link_ok       = link_q;

endmodule

// File: tb/tb_game_state_mux.sv
// Directed bench for game_state_mux: a table of one-cycle vectors with
// hand-computed expected outputs, followed by hand-written sequences for
// link timeout, coincident receive/tick and mid-frame reset.
module tb_game_state_mux;
    import game_state_mux_pkg::*;

    localparam int XW = 11;
    localparam int YW = 10;
    localparam int XC = 312;   // (640-16)/2
    localparam int YC = 232;   // (480-16)/2
    localparam int PC = 200;   // (480-80)/2

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    game_state_mux_if #(.X_W(XW), .Y_W(YW)) bus ();

    game_state_mux #(
        .X_W            (XW),
        .Y_W            (YW),
        .TIMEOUT_FRAMES (4),
        .DEB_FRAMES     (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sw;
        bit         ft;
        bit         uv;
        int         ux;
        int         uy;
        int         upad;
        int         ylog;
        int         ex;
        int         ey;
        int         ep1;
        int         ep2;
        mux_mode_t  em;
        bit         el;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input int ex, input int ey, input int ep1,
                           input int ep2, input mux_mode_t em, input bit el);
        chk({nm, "_x"},    int'(bus.x_ball_mux),    ex);
        chk({nm, "_y"},    int'(bus.y_ball_mux),    ey);
        chk({nm, "_p1"},   int'(bus.y_player1_mux), ep1);
        chk({nm, "_p2"},   int'(bus.y_player2_mux), ep2);
        chk({nm, "_mode"}, int'(bus.mode_active),   int'(em));
        chk({nm, "_link"}, int'(bus.link_ok),       int'(el));
    endtask

    // One clock cycle of stimulus; returns at the following falling edge so
    // the outputs of the edge that sampled these inputs are visible.
    task automatic drive(input logic [1:0] s, input bit ft, input bit uv,
                         input int ux, input int uy, input int upad, input int ylog);
        @(negedge clk);
        bus.sw           = s;
        bus.frame_tick   = ft;
        bus.uart_valid   = uv;
        bus.x_ball_uart  = XW'(ux);
        bus.y_ball_uart  = YW'(uy);
        bus.y_pad_uart   = YW'(upad);
        bus.y_ball_logic = YW'(ylog);
        @(negedge clk);
        bus.frame_tick = 1'b0;
        bus.uart_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.sw              = 2'b00;
        bus.frame_tick      = 1'b0;
        bus.uart_valid      = 1'b0;
        bus.x_ball_logic    = XW'(50);
        bus.y_ball_logic    = YW'(60);
        bus.y_player1_logic = YW'(100);
        bus.y_player2_logic = YW'(400);
        bus.x_ball_uart     = '0;
        bus.y_ball_uart     = '0;
        bus.y_pad_uart      = '0;

        //          sw    ft uv  ux  uy  pad ylog  ex  ey  p1   p2  mode         link
        vecs[0]  = '{2'b00, 0, 0, 0,   0,   0,  60, XC, YC, PC,  PC, MODE_LOCAL, 0};
        vecs[1]  = '{2'b00, 1, 0, 0,   0,   0,  60, 50, 60, 100, 400, MODE_LOCAL, 0};
        vecs[2]  = '{2'b00, 1, 0, 0,   0,   0,  60, 50, 60, 100, PC, MODE_HOST,  0};
        vecs[3]  = '{2'b00, 1, 0, 0,   0,   0,  60, 50, 60, 100, PC, MODE_HOST,  0};
        vecs[4]  = '{2'b00, 0, 1, 500, 210, 300, 70, 50, 60, 100, PC, MODE_HOST,  0};
        vecs[5]  = '{2'b00, 0, 0, 0,   0,   0,  70, 50, 60, 100, PC, MODE_HOST,  0};
        vecs[6]  = '{2'b00, 1, 0, 0,   0,   0,  70, 50, 70, 100, 300, MODE_HOST, 1};
        vecs[7]  = '{2'b01, 0, 0, 0,   0,   0,  70, 50, 70, 100, 300, MODE_HOST, 1};
        vecs[8]  = '{2'b01, 1, 0, 0,   0,   0,  70, 50, 70, 100, 300, MODE_HOST, 1};
        vecs[9]  = '{2'b00, 1, 0, 0,   0,   0,  70, 50, 70, 100, 300, MODE_HOST, 1};
        vecs[10] = '{2'b00, 1, 0, 0,   0,   0,  70, 50, 70, 100, PC, MODE_HOST,  0};
        vecs[11] = '{2'b10, 1, 0, 0,   0,   0,  70, 50, 70, 100, PC, MODE_HOST,  0};
        vecs[12] = '{2'b10, 1, 0, 0,   0,   0,  70, 50, 70, 100, 400, MODE_LOCAL, 0};
        vecs[13] = '{2'b10, 0, 0, 0,   0,   0,  80, 50, 70, 100, 400, MODE_LOCAL, 0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_all("reset", XC, YC, PC, PC, MODE_LOCAL, 1'b0);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].sw, vecs[i].ft, vecs[i].uv, vecs[i].ux, vecs[i].uy,
                  vecs[i].upad, vecs[i].ylog);
            chk_all($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].ep1,
                    vecs[i].ep2, vecs[i].em, vecs[i].el);
        end

        // Enter CLIENT with the link down: all remote fields centred.
        drive(2'b01, 1, 0, 0, 0, 0, 80);
        chk_all("cl_t1", 50, 80, 100, 400, MODE_LOCAL, 1'b0);
        drive(2'b01, 1, 0, 0, 0, 0, 80);
        chk_all("cl_t2", XC, YC, PC, 100, MODE_CLIENT, 1'b0);

        // Fresh frame then silence: held for three ticks, centred on the fourth.
        drive(2'b01, 0, 1, 500, 200, 250, 80);
        chk_all("to_rx", XC, YC, PC, 100, MODE_CLIENT, 1'b0);
        for (int t = 1; t <= 4; t++) begin
            drive(2'b01, 1, 0, 0, 0, 0, 80);
            if (t < 4) chk_all($sformatf("to_t%0d", t), 500, 200, 250, 100, MODE_CLIENT, 1'b1);
            else       chk_all("to_t4", XC, YC, PC, 100, MODE_CLIENT, 1'b0);
        end
        drive(2'b01, 0, 1, 501, 201, 251, 80);
        chk_all("re_rx", XC, YC, PC, 100, MODE_CLIENT, 1'b0);
        drive(2'b01, 1, 0, 0, 0, 0, 80);
        chk_all("re_t", 501, 201, 251, 100, MODE_CLIENT, 1'b1);

        // Receive coincident with a tick: old shadow committed, age cleared.
        drive(2'b01, 0, 1, 10, 10, 10, 80);
        drive(2'b01, 1, 0, 0, 0, 0, 80);
        chk_all("co_old", 10, 10, 10, 100, MODE_CLIENT, 1'b1);
        drive(2'b01, 1, 1, 20, 20, 20, 80);
        chk_all("co_same", 10, 10, 10, 100, MODE_CLIENT, 1'b1);
        drive(2'b01, 1, 0, 0, 0, 0, 80);
        chk_all("co_new", 20, 20, 20, 100, MODE_CLIENT, 1'b1);
        drive(2'b01, 1, 0, 0, 0, 0, 80);
        drive(2'b01, 1, 0, 0, 0, 0, 80);
        chk("co_age3_link", int'(bus.link_ok), 1);
        drive(2'b01, 1, 0, 0, 0, 0, 80);
        chk_all("co_age4", XC, YC, PC, 100, MODE_CLIENT, 1'b0);

        // Mid-frame reset in CLIENT with a live link.
        drive(2'b01, 0, 1, 30, 40, 50, 80);
        drive(2'b01, 1, 0, 0, 0, 0, 80);
        chk_all("rs_pre", 30, 40, 50, 100, MODE_CLIENT, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_all("rs_now", XC, YC, PC, PC, MODE_LOCAL, 1'b0);
        drive(2'b01, 0, 0, 0, 0, 0, 80);
        chk_all("rs_idle", XC, YC, PC, PC, MODE_LOCAL, 1'b0);
        drive(2'b01, 1, 0, 0, 0, 0, 80);
        chk_all("rs_t1", 50, 80, 100, 400, MODE_LOCAL, 1'b0);
        drive(2'b01, 1, 0, 0, 0, 0, 80);
        chk_all("rs_t2", XC, YC, PC, 100, MODE_CLIENT, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
